adc_max10_core: RTL and testbench
=================================

Name: adc_max10_core

Overview:
- Register-mapped controller for the MAX10 on-chip ADC sequencer IP (Avalon-ST command/response interface).
- Software programs a channel mask and a control/status register over a simple synchronous read/write bus.
- Core scans enabled channels, stores 12-bit results in per-channel data registers, and raises an optional interrupt at end of scan.
- Scans start by software (SC bit) or by an external trigger input.

Parameters:
- ADC_ADDR_WIDTH, 4, register address width.
- ADC_CHANNELS, 8, number of channels/data registers; register index i maps to ADC hardware channel i.

Ports:
- CLK  in  1  system clock; ADC IP command/response side runs on it.
- RESETn  in  1  reset, synchronous, active-low.
- read_addr  in  ADC_ADDR_WIDTH  register read address.
- read_data  out  32  read data; combinational from read_addr.
- write_addr  in  ADC_ADDR_WIDTH  register write address.
- write_data  in  32  write data.
- write_enable  in  1  write strobe, sampled on posedge CLK.
- ADC_C_Valid  out  1  command valid.
- ADC_C_Channel  out  5  command channel.
- ADC_C_SOP  out  1  command start of packet.
- ADC_C_EOP  out  1  command end of packet.
- ADC_C_Ready  in  1  command accepted.
- ADC_R_Valid  in  1  response valid.
- ADC_R_Channel  in  5  response channel.
- ADC_R_Data  in  12  conversion result.
- ADC_R_SOP  in  1  response SOP (ignored).
- ADC_R_EOP  in  1  response EOP (ignored).
- ADC_Trigger  in  1  external scan trigger.
- ADC_Interrupt  out  1  interrupt request.

Behaviour:
- Register map:
  - 0 ADCS, control/status.
  - 1 ADMSK, channel mask, bits [ADC_CHANNELS-1:0] RW, upper bits read 0.
  - 2+i ADCi data, read-only: {20'b0, data[11:0]}.
  - Other addresses read 0; writes to them and to data registers are ignored.
- ADCS bits:
  - 0 EN: enable.
  - 1 SC: start/busy.
  - 2 TE: trigger enable.
  - 3 IE: interrupt enable.
  - 4 IF: interrupt flag.
  - Others read 0.
- Reset (RESETn=0 at posedge): all registers 0, FSM IDLE, ADC_C_Valid/SOP/EOP/Channel 0, ADC_Interrupt 0. Reset mid-scan aborts immediately.
- Write timing: registers update at posedge CLK when write_enable=1. read_data reflects new value in the same cycle after that edge.
- Scan start in IDLE:
  - Software write with EN=1 and SC=1, or rising edge of ADC_Trigger (edge-detected against registered previous value) while EN=1 and TE=1.
  - Next cycle: SC reads 1, ADMSK latched as scan mask.
  - Start requests while busy or EN=0 are ignored; SC stays 0 when EN=0.
- FSM states:
  - IDLE: wait for a start request.
  - SELECT: pick the lowest remaining set mask bit. If none, go to DONE.
  - CMD: ADC_C_Valid=1, ADC_C_Channel=channel, SOP=EOP=1, held stable until the cycle ADC_C_Ready=1. Then clear that mask bit and go to WAIT.
  - WAIT: on ADC_R_Valid, go to SELECT.
  - DONE: clear SC, set IF, go to IDLE.
- Empty mask: scan completes in 2 cycles, with no command issued and IF set.
- Response capture (any state): ADC_R_Valid=1 and ADC_R_Channel < ADC_CHANNELS writes ADC_R_Data into data register ADC_R_Channel. Other channels are dropped.
- ADC_Interrupt = IF & IE (registered bits, combinational AND).
- IF is cleared only by a software write of 0 to bit 4. A hardware set in the same cycle wins.
- Software write to ADCS while busy: EN/TE/IE/IF update normally; the SC bit of the write is ignored.
- EN cleared while busy:
  - FSM aborts to IDLE next cycle; ADC_C_Valid drops; SC clears; IF not set.
  - A late response is still captured.

Test Plan:
- Reset then read all addresses -> every register reads 0; ADC_C_Valid=0; ADC_Interrupt=0.
- Write ADMSK=0x02; ADCS=0x0F; model responds ch1 data 0xABC -> command asserted with channel 1, SOP=EOP=1. After response: ADC1 reads 0x00000ABC, ADCS reads 0x1D (SC cleared, IF set), ADC_Interrupt=1.
- ADMSK=0x85, start scan -> commands issued in order 0, 2, 7, each only after the previous response; data lands in ADC0/ADC2/ADC7; IF set after the third response.
- ADMSK=0x01, ADCS=0x05 (EN, TE), pulse ADC_Trigger -> one scan. Second pulse while busy -> ignored. Trigger with TE=0 -> no command.
- With IF=1 and IE=1, write ADCS=0x09 -> IF=0, ADC_Interrupt=0. Write SC=1 with EN=0 -> no command, SC reads 0.
- Hold ADC_C_Ready=0 then clear EN mid-command -> Valid drops next cycle, SC=0, IF=0. ADMSK=0 start -> IF set in 2 cycles with no command.

Source files
------------

// File: rtl/adc_max10_core.sv
// Register-mapped scan controller for the MAX10 ADC sequencer IP (Avalon-ST command/response).
// Scans enabled channels in ascending order and keeps one 12-bit result register per channel.
module adc_max10_core #(
  parameter int ADC_ADDR_WIDTH = 4,
  parameter int ADC_CHANNELS   = 8
) (
  input  logic                      CLK,
  input  logic                      RESETn,
  input  logic [ADC_ADDR_WIDTH-1:0] read_addr,
  output logic [31:0]               read_data,
  input  logic [ADC_ADDR_WIDTH-1:0] write_addr,
  input  logic [31:0]               write_data,
  input  logic                      write_enable,
  output logic                      ADC_C_Valid,
  output logic [4:0]                ADC_C_Channel,
  output logic                      ADC_C_SOP,
  output logic                      ADC_C_EOP,
  input  logic                      ADC_C_Ready,
  input  logic                      ADC_R_Valid,
  input  logic [4:0]                ADC_R_Channel,
  input  logic [11:0]               ADC_R_Data,
  input  logic                      ADC_R_SOP,
  input  logic                      ADC_R_EOP,
  input  logic                      ADC_Trigger,
  output logic                      ADC_Interrupt
);

  localparam int CW = (ADC_CHANNELS > 1) ? $clog2(ADC_CHANNELS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_CMD, S_WAIT, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic                    en_q, en_d, sc_q, sc_d, te_q, te_d, ie_q, ie_d, irq_flag_q, irq_flag_d;
  logic                    trig_q, trig_d;
  logic [ADC_CHANNELS-1:0] mask_q, mask_d, scan_q, scan_d;
  logic [11:0]             data_q [ADC_CHANNELS];
  logic [11:0]             data_d [ADC_CHANNELS];
  logic                    c_valid_q, c_valid_d;
  logic [4:0]              c_chan_q, c_chan_d;

  logic                    wr_adcs, wr_mask, start, abort, if_set, found;
  logic [CW-1:0]           low_idx;
  logic [ADC_ADDR_WIDTH-1:0] ridx;
  logic                    unused_ok;

  assign unused_ok = ^{ADC_R_SOP, ADC_R_EOP, write_data, ridx};

  always_comb begin
    found   = 1'b0;
    low_idx = '0;
    for (int unsigned i = 0; i < ADC_CHANNELS; i++) begin
      if (scan_q[i] && !found) begin
        found   = 1'b1;
        low_idx = CW'(i);
      end
    end
  end

  always_comb begin
    wr_adcs = write_enable && (write_addr == '0);
    wr_mask = write_enable && (write_addr == ADC_ADDR_WIDTH'(1));
    en_d    = wr_adcs ? write_data[0] : en_q;
    te_d    = wr_adcs ? write_data[2] : te_q;
    ie_d    = wr_adcs ? write_data[3] : ie_q;
    mask_d  = wr_mask ? write_data[ADC_CHANNELS-1:0] : mask_q;
    trig_d  = ADC_Trigger;

    // Abort keys off the post-write EN so clearing EN stops the scan at the same edge.
    abort = (state_q != S_IDLE) && !en_d;
    start = (state_q == S_IDLE) &&
            ((wr_adcs && write_data[0] && write_data[1]) ||
             (ADC_Trigger && !trig_q && en_q && te_q && en_d));

    state_d   = state_q;
    sc_d      = sc_q;
    scan_d    = scan_q;
    c_valid_d = c_valid_q;
    c_chan_d  = c_chan_q;
    if_set    = 1'b0;

    if (abort) begin
      state_d   = S_IDLE;
      sc_d      = 1'b0;
      c_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d = S_SELECT;
          sc_d    = 1'b1;
          scan_d  = mask_q;
        end
        S_SELECT: if (found) begin
          state_d   = S_CMD;
          c_valid_d = 1'b1;
          c_chan_d  = 5'(low_idx);
        end else begin
          state_d = S_DONE;
        end
        S_CMD: if (ADC_C_Ready) begin
          scan_d[c_chan_q[CW-1:0]] = 1'b0;
          c_valid_d                = 1'b0;
          state_d                  = S_WAIT;
        end
        S_WAIT: if (ADC_R_Valid) state_d = S_SELECT;
        S_DONE: begin
          sc_d    = 1'b0;
          if_set  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    irq_flag_d = if_set ? 1'b1 : (wr_adcs ? write_data[4] : irq_flag_q);

    data_d = data_q;
    if (ADC_R_Valid && (32'(ADC_R_Channel) < 32'(ADC_CHANNELS)))
      data_d[ADC_R_Channel[CW-1:0]] = ADC_R_Data;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      sc_q       <= 1'b0;
      te_q       <= 1'b0;
      ie_q       <= 1'b0;
      irq_flag_q <= 1'b0;
      trig_q     <= 1'b0;
      mask_q     <= '0;
      scan_q     <= '0;
      c_valid_q  <= 1'b0;
      c_chan_q   <= '0;
      for (int unsigned i = 0; i < ADC_CHANNELS; i++) data_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      sc_q       <= sc_d;
      te_q       <= te_d;
      ie_q       <= ie_d;
      irq_flag_q <= irq_flag_d;
      trig_q     <= trig_d;
      mask_q     <= mask_d;
      scan_q     <= scan_d;
      c_valid_q  <= c_valid_d;
      c_chan_q   <= c_chan_d;
      data_q     <= data_d;
    end
  end

  assign ADC_C_Valid   = c_valid_q;
  assign ADC_C_Channel = c_chan_q;
  assign ADC_C_SOP     = c_valid_q;
  assign ADC_C_EOP     = c_valid_q;
  assign ADC_Interrupt = irq_flag_q & ie_q;

  always_comb begin
    read_data = '0;
    ridx      = read_addr - ADC_ADDR_WIDTH'(2);
    if (read_addr == '0)
      read_data = {27'b0, irq_flag_q, ie_q, te_q, sc_q, en_q};
    else if (read_addr == ADC_ADDR_WIDTH'(1))
      read_data = 32'(mask_q);
    else if (32'(read_addr) < 32'(ADC_CHANNELS + 2))
      read_data = {20'b0, data_q[ridx[CW-1:0]]};
  end

endmodule

// File: tb/tb_adc_max10_core.sv
// Bench for adc_max10_core: acts as the ADC sequencer IP and checks against a register-level model.
module tb_adc_max10_core;

  localparam int AW  = 4;
  localparam int NCH = 8;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic [AW-1:0] read_addr = '0;
  logic [31:0]   read_data;
  logic [AW-1:0] write_addr = '0;
  logic [31:0]   write_data = '0;
  logic          write_enable = 1'b0;
  logic          ADC_C_Valid, ADC_C_SOP, ADC_C_EOP, ADC_Interrupt;
  logic [4:0]    ADC_C_Channel;
  logic          ADC_C_Ready = 1'b0;
  logic          ADC_R_Valid = 1'b0;
  logic [4:0]    ADC_R_Channel = '0;
  logic [11:0]   ADC_R_Data = '0;
  logic          ADC_R_SOP = 1'b0, ADC_R_EOP = 1'b0, ADC_Trigger = 1'b0;

  int unsigned n_cmp = 0, n_bad = 0;
  logic [11:0] ref_data [NCH];

  always #5 CLK = ~CLK;

  adc_max10_core #(.ADC_ADDR_WIDTH(AW), .ADC_CHANNELS(NCH)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .read_addr(read_addr), .read_data(read_data),
    .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
    .ADC_C_Valid(ADC_C_Valid), .ADC_C_Channel(ADC_C_Channel),
    .ADC_C_SOP(ADC_C_SOP), .ADC_C_EOP(ADC_C_EOP), .ADC_C_Ready(ADC_C_Ready),
    .ADC_R_Valid(ADC_R_Valid), .ADC_R_Channel(ADC_R_Channel), .ADC_R_Data(ADC_R_Data),
    .ADC_R_SOP(ADC_R_SOP), .ADC_R_EOP(ADC_R_EOP),
    .ADC_Trigger(ADC_Trigger), .ADC_Interrupt(ADC_Interrupt)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [31:0] d);
    read_addr = a;
    #1;
    d = read_data;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    write_addr   = a;
    write_data   = d;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    write_data   = '0;
  endtask

  task automatic respond(input int ch, input logic [11:0] d);
    ADC_R_Valid   = 1'b1;
    ADC_R_Channel = 5'(ch);
    ADC_R_Data    = d;
    tick();
    ADC_R_Valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    RESETn = 1'b0;
    tick(); tick();
    RESETn = 1'b1;
    wr(1, 32'hFF);
    wr(0, 32'h1C);
    respond(3, 12'h5A5);
    if (ADC_Interrupt !== 1'b1) begin n_bad++; $display("FAIL pre_reset_irq: got %b want 1", ADC_Interrupt); end
    n_cmp++;
    RESETn = 1'b0;
    tick();
    RESETn = 1'b1;
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), r);
      if (r !== 32'h0) begin n_bad++; $display("FAIL reset_reg[%0d]: got %h want 0", a, r); end
      n_cmp++;
    end
    if ({ADC_C_Valid, ADC_C_SOP, ADC_C_EOP, ADC_C_Channel, ADC_Interrupt} !== 9'h0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", {ADC_C_Valid, ADC_C_SOP, ADC_C_EOP, ADC_C_Channel, ADC_Interrupt});
    end
    n_cmp++;
    for (int i = 0; i < NCH; i++) ref_data[i] = '0;
  endtask

  task automatic test_scan();
    logic [31:0] r;
    logic [7:0]  m;
    logic [11:0] dat;
    int          q[$];
    int          ch, w;
    for (int k = 0; k < 6; k++) begin
      m = (k == 0) ? 8'h02 : (k == 1) ? 8'h85 : 8'($urandom_range(1, 255));
      wr(1, {24'b0, m});
      wr(0, 32'h0F);
      rd(0, r);
      if (r !== 32'h0F) begin n_bad++; $display("FAIL scan_busy_adcs: got %h want 0000000f", r); end
      n_cmp++;
      q = {};
      for (int i = 0; i < NCH; i++) if (m[i]) q.push_back(i);
      foreach (q[j]) begin
        ch = q[j];
        w  = 0;
        while (ADC_C_Valid !== 1'b1 && w < 20) begin tick(); w++; end
        if (ADC_C_Valid !== 1'b1) begin n_bad++; $display("FAIL cmd_timeout: got %b want 1 (ch %0d)", ADC_C_Valid, ch); end
        n_cmp++;
        if ({ADC_C_Channel, ADC_C_SOP, ADC_C_EOP} !== {5'(ch), 2'b11}) begin
          n_bad++; $display("FAIL cmd_fields: got ch %0d sop %b eop %b want ch %0d sop 1 eop 1", ADC_C_Channel, ADC_C_SOP, ADC_C_EOP, ch);
        end
        n_cmp++;
        repeat ($urandom_range(0, 3)) begin
          tick();
          if ({ADC_C_Valid, ADC_C_Channel} !== {1'b1, 5'(ch)}) begin
            n_bad++; $display("FAIL cmd_hold: got v %b ch %0d want v 1 ch %0d", ADC_C_Valid, ADC_C_Channel, ch);
          end
          n_cmp++;
        end
        ADC_C_Ready = 1'b1;
        tick();
        ADC_C_Ready = 1'b0;
        if (ADC_C_Valid !== 1'b0) begin n_bad++; $display("FAIL cmd_drop: got %b want 0", ADC_C_Valid); end
        n_cmp++;
        repeat ($urandom_range(0, 3)) begin
          tick();
          if (ADC_C_Valid !== 1'b0) begin n_bad++; $display("FAIL wait_no_cmd: got %b want 0", ADC_C_Valid); end
          n_cmp++;
        end
        if (ADC_Interrupt !== 1'b0) begin n_bad++; $display("FAIL irq_early: got %b want 0", ADC_Interrupt); end
        n_cmp++;
        dat = 12'($urandom);
        respond(ch, dat);
        ref_data[ch] = dat;
        rd(4'(2 + ch), r);
        if (r !== {20'b0, dat}) begin n_bad++; $display("FAIL data_capture[%0d]: got %h want %h", ch, r, {20'b0, dat}); end
        n_cmp++;
      end
      tick();
      if (ADC_Interrupt !== 1'b0) begin n_bad++; $display("FAIL irq_latency: got %b want 0", ADC_Interrupt); end
      n_cmp++;
      tick();
      if (ADC_Interrupt !== 1'b1) begin n_bad++; $display("FAIL irq_set: got %b want 1", ADC_Interrupt); end
      n_cmp++;
      rd(0, r);
      if (r !== 32'h1D) begin n_bad++; $display("FAIL scan_done_adcs: got %h want 0000001d", r); end
      n_cmp++;
      rd(1, r);
      if (r !== {24'b0, m}) begin n_bad++; $display("FAIL mask_read: got %h want %h", r, {24'b0, m}); end
      n_cmp++;
      for (int i = 0; i < NCH; i++) begin
        rd(4'(2 + i), r);
        if (r !== {20'b0, ref_data[i]}) begin n_bad++; $display("FAIL data_reg[%0d]: got %h want %h", i, r, {20'b0, ref_data[i]}); end
        n_cmp++;
      end
    end
  endtask

  task automatic test_capture();
    logic [31:0] r;
    logic [11:0] dat;
    for (int k = 0; k < 4; k++) respond($urandom_range(NCH, 31), 12'($urandom));
    respond(NCH, 12'hFFF);
    for (int i = 0; i < NCH; i++) begin
      rd(4'(2 + i), r);
      if (r !== {20'b0, ref_data[i]}) begin n_bad++; $display("FAIL drop_out_of_range[%0d]: got %h want %h", i, r, {20'b0, ref_data[i]}); end
      n_cmp++;
    end
    dat = 12'($urandom);
    respond(NCH - 1, dat);
    ref_data[NCH-1] = dat;
    rd(4'(NCH + 1), r);
    if (r !== {20'b0, dat}) begin n_bad++; $display("FAIL idle_capture_last: got %h want %h", r, {20'b0, dat}); end
    n_cmp++;
    rd(4'(NCH + 2), r);
    if (r !== 32'h0) begin n_bad++; $display("FAIL unmapped_read: got %h want 0", r); end
    n_cmp++;
  endtask

  task automatic test_trigger();
    logic [31:0] r;
    logic [11:0] dat;
    int w, hits;
    wr(1, 32'h01);
    wr(0, 32'h05);
    ADC_Trigger = 1'b1;
    tick();
    rd(0, r);
    if (r !== 32'h07) begin n_bad++; $display("FAIL trig_start: got %h want 00000007", r); end
    n_cmp++;
    ADC_Trigger = 1'b0;
    w = 0;
    while (ADC_C_Valid !== 1'b1 && w < 20) begin tick(); w++; end
    if ({ADC_C_Valid, ADC_C_Channel} !== 6'b1_00000) begin
      n_bad++; $display("FAIL trig_cmd: got v %b ch %0d want v 1 ch 0", ADC_C_Valid, ADC_C_Channel);
    end
    n_cmp++;
    tick();
    ADC_Trigger = 1'b1;
    tick();
    ADC_Trigger = 1'b0;
    ADC_C_Ready = 1'b1;
    tick();
    ADC_C_Ready = 1'b0;
    dat = 12'($urandom);
    respond(0, dat);
    ref_data[0] = dat;
    tick(); tick();
    rd(0, r);
    if (r !== 32'h15) begin n_bad++; $display("FAIL trig_done: got %h want 00000015", r); end
    n_cmp++;
    hits = 0;
    repeat (10) begin tick(); if (ADC_C_Valid === 1'b1) hits++; end
    if (hits !== 0) begin n_bad++; $display("FAIL trig_busy_ignored: got %0d cmd cycles want 0", hits); end
    n_cmp++;
    wr(0, 32'h01);
    ADC_Trigger = 1'b1; tick(); ADC_Trigger = 1'b0;
    hits = 0;
    repeat (10) begin tick(); if (ADC_C_Valid === 1'b1) hits++; end
    if (hits !== 0) begin n_bad++; $display("FAIL trig_te_off: got %0d cmd cycles want 0", hits); end
    n_cmp++;
    rd(0, r);
    if (r !== 32'h01) begin n_bad++; $display("FAIL trig_te_off_adcs: got %h want 00000001", r); end
    n_cmp++;
    ADC_Trigger = 1'b1;
    tick();
    wr(0, 32'h05);
    hits = 0;
    repeat (6) begin tick(); if (ADC_C_Valid === 1'b1) hits++; end
    if (hits !== 0) begin n_bad++; $display("FAIL trig_level_no_edge: got %0d cmd cycles want 0", hits); end
    n_cmp++;
    ADC_Trigger = 1'b0;
    wr(0, 32'h0);
  endtask

  task automatic test_if_clear();
    logic [31:0] r;
    int hits;
    wr(1, 32'h0);
    wr(0, 32'h0B);
    rd(0, r);
    if (r !== 32'h0B) begin n_bad++; $display("FAIL empty_busy: got %h want 0000000b", r); end
    n_cmp++;
    hits = (ADC_C_Valid === 1'b1) ? 1 : 0;
    tick();
    if (ADC_C_Valid === 1'b1) hits++;
    if (ADC_Interrupt !== 1'b0) begin n_bad++; $display("FAIL empty_irq_early: got %b want 0", ADC_Interrupt); end
    n_cmp++;
    tick();
    if (ADC_Interrupt !== 1'b1) begin n_bad++; $display("FAIL empty_irq_2cyc: got %b want 1", ADC_Interrupt); end
    n_cmp++;
    if (hits !== 0) begin n_bad++; $display("FAIL empty_no_cmd: got %0d cmd cycles want 0", hits); end
    n_cmp++;
    rd(0, r);
    if (r !== 32'h19) begin n_bad++; $display("FAIL empty_done_adcs: got %h want 00000019", r); end
    n_cmp++;
    wr(0, 32'h09);
    rd(0, r);
    if ({r, ADC_Interrupt} !== {32'h09, 1'b0}) begin n_bad++; $display("FAIL if_clear: got %h irq %b want 00000009 irq 0", r, ADC_Interrupt); end
    n_cmp++;
    wr(0, 32'h02);
    hits = 0;
    repeat (5) begin tick(); if (ADC_C_Valid === 1'b1) hits++; end
    rd(0, r);
    if ({r, hits} !== {32'h0, 32'd0}) begin n_bad++; $display("FAIL sc_without_en: got %h cmds %0d want 0 cmds 0", r, hits); end
    n_cmp++;
  endtask

  task automatic test_abort();
    logic [31:0] r;
    logic [11:0] dat;
    int w, hits;
    wr(1, 32'h10);
    wr(0, 32'h0F);
    w = 0;
    while (ADC_C_Valid !== 1'b1 && w < 20) begin tick(); w++; end
    if ({ADC_C_Valid, ADC_C_Channel} !== {1'b1, 5'd4}) begin n_bad++; $display("FAIL abort_cmd: got v %b ch %0d want v 1 ch 4", ADC_C_Valid, ADC_C_Channel); end
    n_cmp++;
    tick(); tick();
    wr(0, 32'h0D);
    rd(0, r);
    if ({r, ADC_C_Valid} !== {32'h0F, 1'b1}) begin n_bad++; $display("FAIL busy_sc_ignored: got %h v %b want 0000000f v 1", r, ADC_C_Valid); end
    n_cmp++;
    wr(0, 32'h0C);
    if (ADC_C_Valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid: got %b want 0", ADC_C_Valid); end
    n_cmp++;
    rd(0, r);
    if (r !== 32'h0C) begin n_bad++; $display("FAIL abort_adcs: got %h want 0000000c", r); end
    n_cmp++;
    hits = 0;
    repeat (5) begin tick(); if (ADC_C_Valid === 1'b1 || ADC_Interrupt === 1'b1) hits++; end
    if (hits !== 0) begin n_bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", hits); end
    n_cmp++;
    dat = 12'($urandom);
    respond(4, dat);
    ref_data[4] = dat;
    rd(6, r);
    if (r !== {20'b0, dat}) begin n_bad++; $display("FAIL late_response: got %h want %h", r, {20'b0, dat}); end
    n_cmp++;
    wr(0, 32'h0F);
    w = 0;
    while (ADC_C_Valid !== 1'b1 && w < 20) begin tick(); w++; end
    RESETn = 1'b0;
    tick();
    RESETn = 1'b1;
    if ({ADC_C_Valid, ADC_C_SOP, ADC_C_EOP} !== 3'b000) begin n_bad++; $display("FAIL reset_mid_scan: got %b want 000", {ADC_C_Valid, ADC_C_SOP, ADC_C_EOP}); end
    n_cmp++;
    hits = 0;
    for (int a = 0; a < 16; a++) begin rd(4'(a), r); if (r !== 32'h0) hits++; end
    if (hits !== 0) begin n_bad++; $display("FAIL reset_mid_scan_regs: got %0d nonzero regs want 0", hits); end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_capture();
    test_trigger();
    test_if_clear();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
